// File: rtl/rr_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb_pkg : shared constants, state type and reset values        |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package rr_arb_pkg;

   localparam int N            = 8;
   localparam int IDX_W        = 3;
   localparam int HOLD_MAX_DEF = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam state_t           RST_STATE = IDLE;
   localparam logic [IDX_W-1:0] RST_PTR   = '0;
   localparam logic [IDX_W-1:0] RST_IDX   = '0;
   localparam logic [N-1:0]     RST_GNT   = '0;

endpackage
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prio_enc8 : 8-to-3 priority encoder, lowest set bit wins          |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module prio_enc8
   import rr_arb_pkg::*;
(
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top down so the lowest set bit is written last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter8 : 8-way round-robin arbiter, grant held until release |
// | Optional RR_ARBITER8_TIMEOUT_EN: forced revoke after HOLD_MAX. R1.0|
// +------------------------------------------------------------------+
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int N        = rr_arb_pkg::N,
   parameter int IDX_W    = rr_arb_pkg::IDX_W,
   parameter int HOLD_MAX = rr_arb_pkg::HOLD_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             revoked
);

   state_t           state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [N-1:0]     gnt_n;
   logic [IDX_W-1:0] idx_n;
   logic             valid_n;

   logic [N-1:0]     req_rot;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_valid;
   logic [IDX_W-1:0] winner;
   logic             owner_req;
   logic             timeout_hit;

   // Rotating right by ptr puts requester ptr at position 0; the 3-bit add wraps mod 8.
   always_comb begin
      req_rot = '0;
      for (int j = 0; j < N; j++) begin
         req_rot[j] = req[IDX_W'(j) + ptr];
      end
   end

   prio_enc8 u_enc (
      .vec   (req_rot),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   assign winner    = ptr + enc_idx;
   assign owner_req = req[gnt_idx];

`ifdef RR_ARBITER8_TIMEOUT_EN
   localparam int HOLD_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

   logic [HOLD_W-1:0] hold_cnt;

   assign timeout_hit = (state == GRANT) && owner_req &&
                        (hold_cnt == HOLD_W'(HOLD_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         revoked  <= 1'b0;
      end else begin
         hold_cnt <= (state == GRANT && state_n == GRANT) ? hold_cnt + 1'b1 : '0;
         revoked  <= timeout_hit;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign revoked     = 1'b0;
`endif

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gnt_n   = gnt;
      idx_n   = gnt_idx;
      valid_n = gnt_valid;
      case (state)
         IDLE: begin
            if (enc_valid) begin
               gnt_n         = '0;
               gnt_n[winner] = 1'b1;
               idx_n         = winner;
               valid_n       = 1'b1;
               state_n       = GRANT;
            end
         end
         GRANT: begin
            // Arbitration never happens on the release edge; IDLE sees the new ptr.
            if (!owner_req || timeout_hit) begin
               gnt_n   = '0;
               idx_n   = '0;
               valid_n = 1'b0;
               ptr_n   = gnt_idx + 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            gnt_n   = '0;
            idx_n   = '0;
            valid_n = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_STATE;
         ptr       <= RST_PTR;
         gnt       <= RST_GNT;
         gnt_idx   <= RST_IDX;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         gnt       <= gnt_n;
         gnt_idx   <= idx_n;
         gnt_valid <= valid_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rr_arbiter8 : table-driven scoreboard bench for rr_arbiter8    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_rr_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       revoked;

   rr_arbiter8 #(.N(8), .IDX_W(3), .HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .revoked   (revoked)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      int         owner;   // -1 means no owner expected
      logic       rev;
   } vec_t;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       rev;
      int         id;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(logic r, logic [7:0] q, int o, logic v);
      vec_t t;
      t.rst   = r;
      t.req   = q;
      t.owner = o;
      t.rev   = v;
      tbl.push_back(t);
   endfunction

   function automatic exp_t mk(int o, logic v, int id);
      exp_t e;
      e.gnt   = (o >= 0) ? (8'h01 << o) : 8'h00;
      e.idx   = (o >= 0) ? 3'(o) : 3'd0;
      e.valid = (o >= 0);
      e.rev   = v;
      e.id    = id;
      return e;
   endfunction

   function automatic void build();
      int o;
      // reset, then idle
      add(1, 8'h00, -1, 0);
      add(1, 8'h00, -1, 0);
      for (int k = 0; k < 5; k++) add(0, 8'h00, -1, 0);
      // single requester 4, release leaves ptr=5
      add(0, 8'h10, 4, 0);
      add(0, 8'h10, 4, 0);
      add(0, 8'h00, -1, 0);
      // rotation from ptr=5 with all requesting
      for (int k = 0; k < 9; k++) begin
         o = (5 + k) % 8;
         add(0, 8'hFF, o, 0);
         add(0, 8'hFF, o, 0);
         add(0, 8'hFF & ~(8'h01 << o), -1, 0);
      end
      // ptr=6: owner 2 ignores toggling of req[0]/req[7]
      add(0, 8'h04, 2, 0);
      for (int k = 0; k < 10; k++) add(0, (k % 2 == 1) ? 8'h85 : 8'h04, 2, 0);
      add(0, 8'h81, -1, 0);
      add(0, 8'h81, 7, 0);
      add(0, 8'h81, 7, 0);
      add(0, 8'h01, -1, 0);
      add(0, 8'h01, 0, 0);
      add(0, 8'h00, -1, 0);
      // ptr=1: reset mid-grant of owner 6 returns ptr to 0
      add(0, 8'h40, 6, 0);
      add(0, 8'h40, 6, 0);
      add(1, 8'h40, -1, 0);
      add(0, 8'h41, 0, 0);
      add(0, 8'h41, 0, 0);
      add(0, 8'h40, -1, 0);
      add(0, 8'h00, -1, 0);
      // ptr=1: requester 1 holds its request
      add(0, 8'h02, 1, 0);
`ifdef RR_ARBITER8_TIMEOUT_EN
      for (int k = 0; k < 3; k++) add(0, 8'h02, 1, 0);
      add(0, 8'h02, -1, 1);
      add(0, 8'h02, 1, 0);
      add(0, 8'h02, 1, 0);
`else
      for (int k = 0; k < 6; k++) add(0, 8'h02, 1, 0);
`endif
      add(0, 8'h00, -1, 0);
   endfunction

   task automatic drive(logic r, logic [7:0] q, int o, logic v, int id);
      @(negedge clk);
      rst = r;
      req = q;
      exp_q.push_back(mk(o, v, id));
   endtask

   task automatic check();
      exp_t e;
      @(posedge clk);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard: no expected entry at vector %0d", n_vec);
         return;
      end
      e = exp_q.pop_front();
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || revoked !== e.rev) begin
         n_bad++;
         $display("FAIL vec%0d: got gnt=%h idx=%0d valid=%b revoked=%b, expected gnt=%h idx=%0d valid=%b revoked=%b",
                  e.id, gnt, gnt_idx, gnt_valid, revoked, e.gnt, e.idx, e.valid, e.rev);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req = 8'h00;
      build();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].owner, tbl[i].rev, i);
         check();
      end

      // request raised and dropped between edges must never be granted
      drive(0, 8'h00, -1, 0, 1000);
      #2 req = 8'h08;
      #2 req = 8'h00;
      check();
      drive(0, 8'h00, -1, 0, 1001);
      check();

      // reset re-applied while idle, then requester 3 from ptr=0
      drive(1, 8'h00, -1, 0, 1002);
      check();
      drive(0, 8'h88, 3, 0, 1003);
      check();
      drive(0, 8'h80, -1, 0, 1004);
      check();
      drive(0, 8'h88, 7, 0, 1005);
      check();

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Produces a one-hot grant plus its 3-bit binary index; the index uses the same encoding as the team's 8-to-3 encoder (bit i -> value i).
- Sits in front of the shared resource; the owner's index steers the downstream mux.
- Grant is held until the owner releases by dropping its request.

Parameters:
- N, 8, number of requesters (block is verified only at 8).
- IDX_W, 3, width of grant index (clog2 of N).
- HOLD_MAX, 16, maximum grant cycles before forced revoke (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i is requester i; held high for the whole ownership.
- gnt  output  8  one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of the owner; 0 when gnt_valid=0.
- gnt_valid  output  1  high while an owner exists.
- revoked  output  1  one-cycle pulse on forced revoke (constant 0 without the optional feature).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, revoked=0, hold counter=0. Reset overrides everything, including mid-grant; the owner loses its grant at that edge.
- All outputs are registered.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, rotate req right by ptr and priority-encode, lowest index first. The winner is w = (ptr + enc) mod 8.
  - Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, state=GRANT.
  - Latency: 1 cycle from req sampled in IDLE to grant visible.
- State GRANT:
  - While req[w]=1, hold all outputs.
  - When req[w]=0 at an edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(w+1) mod 8 (3-bit wrap, so 7 -> 0), state=IDLE.
  - Changes to other req bits during GRANT are ignored.
- Back-to-back handover:
  - Release edge -> one IDLE cycle -> new grant on the following edge.
  - There is always at least one cycle with gnt_valid=0 between owners.
- Fairness: a continuously requesting client waits at most 7 other grants.
- Simultaneous release and new requests: the release edge only moves to IDLE; arbitration happens in IDLE using the updated ptr.
- A request raised and dropped within IDLE before being sampled is never granted.
- Invariants: gnt is always 0 or one-hot; gnt_idx equals the encoding of gnt; gnt_valid equals (gnt != 0).

Optional Feature:
- Macro: RR_ARBITER8_TIMEOUT_EN.
- Defined:
  - The hold counter increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with req[w] still high, the next edge forces release exactly as a normal release (ptr=w+1) and pulses revoked=1 for one cycle.
  - The counter clears on entering GRANT.
  - If the owner keeps req high after revoke, it competes again in IDLE at lowest rotated priority.
- Undefined: no counter logic, revoke path absent, revoked tied 0, grants last indefinitely.

Decomposition:
- Package rr_arb_pkg holds:
  - constants N=8, IDX_W=3;
  - state typedef {IDLE, GRANT};
  - reset-value constants.
- Sub-module prio_enc8:
  - combinational 8-to-3 lowest-index-first encoder with a valid output;
  - instantiated once on the rotated request vector.
- Rotation and the final modulo add stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> gnt=0, gnt_idx=0, gnt_valid=0 for 5 cycles.
- Single requester: req=8'h10 from IDLE -> after 1 edge gnt=8'h10, gnt_idx=4, gnt_valid=1. Drop req -> next edge gnt=0, and ptr=5 is observable via the next test.
- Rotation: with ptr=5, req=8'hFF held, each owner drops after 2 cycles -> grant order 5,6,7,0,1,2,3,4,5 with exactly one gnt_valid=0 cycle between owners.
- Hold and ignore: owner 2 granted; toggle req[0] and req[7] for 10 cycles -> gnt stays 8'h04. On release with req=8'h81 pending and ptr=3 -> next owner is 7, then 0.
- Reset mid-grant: owner 6 active, pulse rst=1 -> next edge gnt=0, ptr=0. With req=8'h41 after reset -> owner 0 granted first.
- Timeout (macro defined, HOLD_MAX=4): req=8'h02 held -> grant for 4 cycles, then revoked=1 for 1 cycle and gnt=0. Next edge it re-enters IDLE and requester 1 is re-granted one edge later. With the macro undefined -> grant persists and revoked=0 throughout.
